// File: rtl/space_invaders_pkg.sv
// Shared types and playfield constants for the Space Invaders game datapath.
package space_invaders_pkg;

  typedef enum logic [1:0] {
    DIR_NONE  = 2'b00,
    DIR_LEFT  = 2'b01,
    DIR_RIGHT = 2'b10
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_FIRST  = 2'b01,
    ST_HOLD   = 2'b10,
    ST_REPEAT = 2'b11
  } move_state_t;

  localparam int SHIP_X_MIN = 0;
  localparam int SHIP_X_MAX = 31;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ship_move_ctrl_dir_arbiter.sv
// Left/right arbitration: a lone held button wins; when both are held the
// most recently pressed one wins, with left taking a same-cycle tie.
module dir_arbiter
  import space_invaders_pkg::*;
(
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_left,
  input  logic i_right,
  output dir_t o_dir
);

  logic prev_left_q;
  logic prev_right_q;
  dir_t last_q;
  dir_t last_d;

  always_comb begin
    last_d = last_q;
    if (i_left && !prev_left_q) begin
      last_d = DIR_LEFT;
    end else if (i_right && !prev_right_q) begin
      last_d = DIR_RIGHT;
    end

    o_dir = DIR_NONE;
    if (i_left && i_right) begin
      o_dir = last_d;
    end else if (i_left) begin
      o_dir = DIR_LEFT;
    end else if (i_right) begin
      o_dir = DIR_RIGHT;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      prev_left_q  <= 1'b0;
      prev_right_q <= 1'b0;
      last_q       <= DIR_LEFT;
    end else begin
      prev_left_q  <= i_left;
      prev_right_q <= i_right;
      last_q       <= last_d;
    end
  end

endmodule

// File: rtl/ship_move_ctrl.sv
// Turns debounced button levels into single-cycle ship move pulses:
// immediate first move, hold delay, then frame-paced auto-repeat.
module ship_move_ctrl
  import space_invaders_pkg::*;
#(
  parameter int X_W           = 5,
  parameter int X_MIN         = SHIP_X_MIN,
  parameter int X_MAX         = SHIP_X_MAX,
  parameter int HOLD_FRAMES   = 8,
  parameter int REPEAT_FRAMES = 2
) (
  input  logic           i_clk_25MHz,
  input  logic           i_reset_n,
  input  logic           i_enable,
  input  logic           i_frame_tick,
  input  logic           i_left_debounced,
  input  logic           i_right_debounced,
  input  logic [X_W-1:0] i_ship_x,
  output logic           o_move_left,
  output logic           o_move_right,
  output logic [1:0]     o_dir
);

  localparam int CNT_MAX = max2(HOLD_FRAMES, REPEAT_FRAMES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_FRAMES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_FRAMES - 1);
  localparam logic [X_W-1:0]   X_MIN_V     = X_W'(X_MIN);
  localparam logic [X_W-1:0]   X_MAX_V     = X_W'(X_MAX);

  move_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dir_t             dir_q, dir_d;
  logic             move_left_q, move_left_d;
  logic             move_right_q, move_right_d;

  dir_t             arb_dir;
  dir_t             req_dir;
  logic             fire;
  logic [CNT_W-1:0] tick_last;

  dir_arbiter u_dir_arbiter (
    .i_clk     (i_clk_25MHz),
    .i_reset_n (i_reset_n),
    .i_left    (i_left_debounced),
    .i_right   (i_right_debounced),
    .o_dir     (arb_dir)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fire         = 1'b0;
    req_dir      = i_enable ? arb_dir : DIR_NONE;
    dir_d        = req_dir;
    tick_last    = (state_q == ST_HOLD) ? HOLD_LAST : REPEAT_LAST;

    // Pausing and releasing both collapse to IDLE with a cleared counter.
    if (req_dir == DIR_NONE) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_FIRST;
          cnt_d   = '0;
        end
        ST_FIRST: begin
          fire    = 1'b1;
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
        ST_HOLD, ST_REPEAT: begin
          if (req_dir != dir_q) begin
            state_d = ST_FIRST;
            cnt_d   = '0;
          end else if (i_frame_tick) begin
            if (cnt_q == tick_last) begin
              fire    = 1'b1;
              state_d = ST_REPEAT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Edge masking only gates the pulse; the sequencing above is unaffected.
    move_left_d  = fire && (req_dir == DIR_LEFT)  && (i_ship_x != X_MIN_V);
    move_right_d = fire && (req_dir == DIR_RIGHT) && (i_ship_x != X_MAX_V);
  end

  always_ff @(posedge i_clk_25MHz or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      dir_q        <= DIR_NONE;
      move_left_q  <= 1'b0;
      move_right_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      move_left_q  <= move_left_d;
      move_right_q <= move_right_d;
    end
  end

  assign o_move_left  = move_left_q;
  assign o_move_right = move_right_q;
  assign o_dir        = dir_q;

endmodule
